// File: rtl/acc_drain_scheduler.sv
// rtl/acc_drain_scheduler.sv - drains accumulator banks onto the 32-bit output bus; optional DRAIN_RELU_EN clamps negative words
module acc_drain_scheduler #(
  parameter int NUM_BANKS = 8,
  parameter int DEPTH     = 3136,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         rd_addr,
  output logic [BANK_W-1:0]         bank_sel,
  output logic                      half_sel,
  input  logic [NUM_BANKS*64-1:0]   bank_rdata,
  input  logic                      bus_free,
  output logic                      valid_o,
  output logic [DATA_W-1:0]         data_o,
  output logic                      busy,
  output logic                      conv_done
);

  localparam int OFF_W = $clog2(NUM_BANKS * 64);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                half_q, half_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic                issue;

  // Read issued last cycle: its data is on bank_rdata now and lands in the FIFO at this edge
  logic                inflight_q;
  logic [BANK_W-1:0]   rd_bank_q;
  logic                rd_half_q;

  // Two-entry FIFO kept as a head register (drives the bus) plus one spare slot
  logic [DATA_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic                head_v_q, head_v_d, tail_v_q, tail_v_d;

  logic                pop;
  logic                push;
  logic [1:0]          used_after_pop;
  logic                last_issue;
  logic [OFF_W-1:0]    sel_off;
  logic [DATA_W-1:0]   sel_word;
  logic [DATA_W-1:0]   push_word;

  assign pop  = head_v_q & bus_free;
  assign push = inflight_q;

  // A slot freed by this cycle's pop is reusable immediately; that keeps 1 word/clk with only 2 entries
  assign used_after_pop = 2'(inflight_q) + 2'(head_v_q) + 2'(tail_v_q) - 2'(pop);

  assign last_issue = (bank_q == BANK_W'(NUM_BANKS - 1)) && half_q &&
                      (addr_q == ADDR_W'(DEPTH - 1));

  // Half 0 is the upper 32 bits of the 64-bit bank word
  assign sel_off  = OFF_W'({rd_bank_q, ~rd_half_q, 5'd0});
  assign sel_word = bank_rdata[sel_off +: DATA_W];

  // Optional clamp applied as the word enters the FIFO, so it adds no latency
  always_comb begin
`ifdef DRAIN_RELU_EN
    push_word = sel_word[DATA_W-1] ? '0 : sel_word;
`else
    push_word = sel_word;
`endif
  end

  // Next-state, read issue and address/half/bank sequencing
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    half_d  = half_q;
    bank_d  = bank_q;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (used_after_pop < 2'd2) begin
          issue = 1'b1;
          if (last_issue) begin
            addr_d  = '0;
            half_d  = 1'b0;
            bank_d  = '0;
            state_d = S_FLUSH;
          end else if (addr_q == ADDR_W'(DEPTH - 1)) begin
            addr_d = '0;
            half_d = ~half_q;
            if (half_q) bank_d = bank_q + 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        // Leave as the final word is being accepted so conv_done follows it by one clock
        if (!inflight_q && !tail_v_q && (!head_v_q || pop)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO update; credits guarantee a push never meets a full FIFO
  always_comb begin
    head_d   = head_q;
    head_v_d = head_v_q;
    tail_d   = tail_q;
    tail_v_d = tail_v_q;
    if (pop) begin
      if (tail_v_q) begin
        head_d   = tail_q;
        tail_v_d = push;
        if (push) tail_d = push_word;
      end else if (push) begin
        head_d = push_word;
      end else begin
        head_v_d = 1'b0;
      end
    end else if (push) begin
      if (!head_v_q) begin
        head_d   = push_word;
        head_v_d = 1'b1;
      end else begin
        tail_d   = push_word;
        tail_v_d = 1'b1;
      end
    end
  end

  // State and read-sequencing registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      half_q  <= 1'b0;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      half_q  <= half_d;
      bank_q  <= bank_d;
    end
  end

  // Delayed copies of the selects, aligned with the returning SRAM data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      rd_bank_q  <= '0;
      rd_half_q  <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        rd_bank_q <= bank_q;
        rd_half_q <= half_q;
      end
    end
  end

  // FIFO storage; head keeps its last value when the FIFO drains empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q   <= '0;
      head_v_q <= 1'b0;
      tail_q   <= '0;
      tail_v_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      head_v_q <= head_v_d;
      tail_q   <= tail_d;
      tail_v_q <= tail_v_d;
    end
  end

  assign rd_en     = issue;
  assign rd_addr   = addr_q;
  assign bank_sel  = bank_q;
  assign half_sel  = half_q;
  assign valid_o   = head_v_q;
  assign data_o    = head_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign conv_done = (state_q == S_DONE);

endmodule

// File: tb/tb_acc_drain_scheduler.sv
// tb/tb_acc_drain_scheduler.sv - scoreboard bench for acc_drain_scheduler
module tb_acc_drain_scheduler;

  localparam int NB    = 8;
  localparam int DEPTH = 40;
  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int BW    = 3;
  localparam int TOTAL = NB * 2 * DEPTH;

  logic                clk;
  logic                rst;
  logic                start;
  logic                rd_en;
  logic [AW-1:0]       rd_addr;
  logic [BW-1:0]       bank_sel;
  logic                half_sel;
  logic [NB*64-1:0]    bank_rdata = '0;
  logic                bus_free;
  logic                valid_o;
  logic [DW-1:0]       data_o;
  logic                busy;
  logic                conv_done;

  int                  n_cmp = 0;
  int                  n_bad = 0;
  bit                  relu_mode = 0;
  logic [31:0]         exp_q[$];

  acc_drain_scheduler #(
    .NUM_BANKS(NB), .DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
    .bank_sel(bank_sel), .half_sel(half_sel), .bank_rdata(bank_rdata),
    .bus_free(bus_free), .valid_o(valid_o), .data_o(data_o), .busy(busy),
    .conv_done(conv_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sram_word(int b, int h, int a);
    if (relu_mode) return (h == 0) ? 32'hFFFF_FFF6 : 32'h0000_000A;
    return (32'(b) << 24) | (32'(h) << 20) | 32'(a);
  endfunction

  function automatic logic [31:0] exp_word(int b, int h, int a);
    logic [31:0] w;
    w = sram_word(b, h, a);
`ifdef DRAIN_RELU_EN
    if (w[31]) w = 32'h0;
`endif
    return w;
  endfunction

  // SRAM model: data one clock after the read strobe
  always @(posedge clk) begin
    if (rd_en) begin
      for (int b = 0; b < NB; b++)
        bank_rdata[b*64 +: 64] <= {sram_word(b, 0, int'(rd_addr)), sram_word(b, 1, int'(rd_addr))};
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check_val({pfx, "_rd_en"},    32'(rd_en),     32'd0);
    check_val({pfx, "_rd_addr"},  32'(rd_addr),   32'd0);
    check_val({pfx, "_bank_sel"}, 32'(bank_sel),  32'd0);
    check_val({pfx, "_half_sel"}, 32'(half_sel),  32'd0);
    check_val({pfx, "_valid"},    32'(valid_o),   32'd0);
    check_val({pfx, "_data"},     data_o,         32'd0);
    check_val({pfx, "_busy"},     32'(busy),      32'd0);
    check_val({pfx, "_done"},     32'(conv_done), 32'd0);
  endtask

  // mode 0: bus always free, 1: random bus_free, 2: bus stalled for 100 clk after start
  task automatic run_drain(input int mode, input int restart_word, input int rst_word);
    int accepted, issued, since, budget, m_addr, m_half, m_bank;
    bit restart_pending, restarted, prev_stall, last_acc, acc_now, finished, do_reset;
    logic [31:0] prev_data, e;
    accepted = 0; issued = 0; since = 0; m_addr = 0; m_half = 0; m_bank = 0;
    restart_pending = 0; restarted = 0; prev_stall = 0; last_acc = 0;
    finished = 0; do_reset = 0; prev_data = '0;
    budget = TOTAL * 6 + 400;
    exp_q.delete();
    for (int b = 0; b < NB; b++)
      for (int h = 0; h < 2; h++)
        for (int a = 0; a < DEPTH; a++)
          exp_q.push_back(exp_word(b, h, a));
    while (!finished) begin
      @(negedge clk);
      start = (since == 0) || restart_pending;
      if (restart_pending) begin
        restarted = 1;
        restart_pending = 0;
      end
      case (mode)
        1:       bus_free = 1'($urandom_range(0, 1));
        2:       bus_free = (since > 100);
        default: bus_free = 1'b1;
      endcase
      if (do_reset) begin
        rst = 1'b1;
        start = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          #1;
          check_val("post_rst_done", 32'(conv_done), 32'd0);
          check_val("post_rst_busy", 32'(busy), 32'd0);
        end
        finished = 1;
      end else begin
        #1;
        if (since >= 1) begin
          if (prev_stall) begin
            check_val("hold_valid", 32'(valid_o), 32'd1);
            check_val("hold_data", data_o, prev_data);
          end
          acc_now = valid_o && bus_free;
          if (acc_now) begin
            if (exp_q.size() == 0) begin
              check_val("word_count", 32'(accepted + 1), 32'(TOTAL));
            end else begin
              e = exp_q.pop_front();
              check_val($sformatf("word%0d", accepted), data_o, e);
            end
            accepted++;
          end
          if (rd_en) begin
            check_val("credit", 32'((issued - accepted) < 2), 32'd1);
            check_val("rd_sel", 32'({bank_sel, half_sel, rd_addr}),
                      32'((m_bank << (AW + 1)) | (m_half << AW) | m_addr));
            issued++;
            if (m_addr == DEPTH - 1) begin
              m_addr = 0;
              if (m_half == 1) m_bank++;
              m_half = 1 - m_half;
            end else begin
              m_addr++;
            end
          end
          if (mode == 0 && since == 2) check_val("first_valid_early", 32'(valid_o), 32'd0);
          if (mode == 0 && since == 3) check_val("first_valid", 32'(valid_o), 32'd1);
          if (mode == 2 && since == 100) begin
            check_val("stall_reads", 32'(issued), 32'd2);
            check_val("stall_valid", 32'(valid_o), 32'd1);
            if (exp_q.size() > 0) check_val("stall_data", data_o, exp_q[0]);
          end
          if (conv_done) begin
            check_val("done_words", 32'(accepted), 32'(TOTAL));
            check_val("done_latency", 32'(last_acc), 32'd1);
            check_val("done_busy", 32'(busy), 32'd0);
            finished = 1;
          end else begin
            check_val("busy", 32'(busy), 32'd1);
          end
          last_acc   = acc_now && (accepted == TOTAL);
          prev_stall = valid_o && !bus_free;
          prev_data  = data_o;
          if (accepted == restart_word && !restarted) restart_pending = 1;
          if (rst_word >= 0 && accepted == rst_word) do_reset = 1;
        end
        since++;
        if (!finished && since > budget) begin
          check_val("timeout", 32'(since), 32'(budget));
          finished = 1;
        end
      end
    end
    if (rst_word < 0) begin
      check_val("issued", 32'(issued), 32'(TOTAL));
      check_val("accepted", 32'(accepted), 32'(TOTAL));
      check_val("left_in_sb", 32'(exp_q.size()), 32'd0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        start = 1'b0;
        #1;
        check_val("after_done", 32'(conv_done), 32'd0);
        check_val("after_busy", 32'(busy), 32'd0);
        check_val("after_rd_en", 32'(rd_en), 32'd0);
        check_val("after_valid", 32'(valid_o), 32'd0);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus_free = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    run_drain(0, TOTAL, -1);
    run_drain(1, -1, -1);
    run_drain(2, -1, -1);
    run_drain(0, 100, -1);
    run_drain(0, -1, 300);
    run_drain(0, -1, -1);
    relu_mode = 1;
    run_drain(1, -1, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
